// File: rtl/alu_mul_seq.sv
// alu_mul_seq: shift-add multiplier borrowing the pipeline ALU; optional early termination via ALU_MUL_SEQ_EARLY_TERM_EN
module alu_mul_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] pipe_a,
  input  logic [31:0] pipe_b,
  input  logic [3:0]  pipe_ctrl,
  input  logic [31:0] alu_result,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_ctrl,
  output logic        stall,
  output logic        done,
  output logic [31:0] product
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [31:0] acc, mcand, mplier;
  logic [4:0]  cnt;
  logic        last, skip;
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
  assign last = (cnt == 5'd31) || (mplier[31:1] == 31'd0);
  assign skip = (op_b == 32'd0);
`else
  assign last = (cnt == 5'd31);
  assign skip = 1'b0;
`endif
  // state register and datapath; product captures the final ALU sum as RUN exits
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        mcand  <= op_a;
        mplier <= op_b;
        acc    <= '0;
        cnt    <= '0;
        if (skip) product <= '0;
      end
      if (state == RUN) begin
        acc    <= alu_result;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 5'd1;
        if (last) product <= alu_result;
      end
    end
  end
  // next state and ALU ownership mux
  always_comb begin
    state_n  = state;
    alu_a    = pipe_a;
    alu_b    = pipe_b;
    alu_ctrl = pipe_ctrl;
    stall    = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: state_n = start ? (skip ? DONE : RUN) : IDLE;
      RUN: begin
        alu_a    = acc;
        alu_b    = mplier[0] ? mcand : '0;
        alu_ctrl = 4'b0000;
        stall    = 1'b1;
        state_n  = last ? DONE : RUN;
      end
      DONE: begin
        alu_a    = acc;
        alu_b    = '0;
        alu_ctrl = 4'b0000;
        stall    = 1'b1;
        done     = 1'b1;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: scoreboard bench for alu_mul_seq with a behavioural shared ALU
module tb_alu_mul_seq;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [31:0] op_a = '0, op_b = '0, pipe_a = '0, pipe_b = '0, alu_result;
  logic [3:0]  pipe_ctrl = '0, alu_ctrl;
  logic [31:0] alu_a, alu_b, product;
  logic        stall, done;
  int checks = 0, errors = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  alu_mul_seq dut (
    .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
    .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_ctrl(pipe_ctrl), .alu_result(alu_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .stall(stall), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  assign alu_result = (alu_ctrl == 4'b0000) ? alu_a + alu_b : alu_a ^ alu_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int latency(input logic [31:0] b);
`ifdef ALU_MUL_SEQ_EARLY_TERM_EN
    int hb = -1;
    for (int i = 0; i < 32; i++) if (b[i]) hb = i;
    return (b == 0) ? 1 : hb + 2;
`else
    return 33;
`endif
  endfunction

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input bit poke_run, input bit poke_done);
    int n;
    logic [31:0] e;
    int l;
    @(negedge clk);
    op_a = a; op_b = b; start = 1'b1;
    exp_q.push_back(a * b);
    lat_q.push_back(latency(b));
    @(negedge clk);
    start = 1'b0; op_a = $urandom; op_b = $urandom;
    n = 1;
    while (!done && n < 60) begin
      check("stall_busy", {31'd0, stall}, 32'd1);
      if (n == 1 && !done) check("run_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      if (poke_run && n == 2) begin start = 1'b1; op_a = 32'd1; op_b = 32'd1; end
      if (n == 3) start = 1'b0;
      @(negedge clk);
      n++;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check("done_seen", {31'd0, done}, 32'd1);
    check("latency", n, l);
    check("product", product, e);
    check("stall_done", {31'd0, stall}, 32'd1);
    if (poke_done) begin start = 1'b1; op_a = 32'd2; op_b = 32'd2; end
    @(negedge clk);
    start = 1'b0;
    check("done_single", {31'd0, done}, 32'd0);
    check("stall_idle", {31'd0, stall}, 32'd0);
    check("alu_a_pass", alu_a, pipe_a);
    @(negedge clk);
    check("stall_idle2", {31'd0, stall}, 32'd0);
    check("product_hold", product, e);
  endtask

  initial begin
    int pulses;
    pipe_a = 32'd5; pipe_b = 32'd9; pipe_ctrl = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_product", product, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("pass_a", alu_a, 32'd5);
    check("pass_b", alu_b, 32'd9);
    check("pass_ctrl", {28'd0, alu_ctrl}, 32'd1);
    check("pass_result", alu_result, 32'd5 ^ 32'd9);
    do_mul(32'd7, 32'd6, 1'b0, 1'b0);
    do_mul(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_mul(32'h80000000, 32'd2, 1'b0, 1'b0);
    do_mul(32'd7, 32'd6, 1'b1, 1'b0);
    do_mul(32'd5, 32'd3, 1'b0, 1'b1);
    do_mul(32'd1234, 32'd0, 1'b0, 1'b0);
    do_mul(32'd0, 32'h80000001, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) do_mul($urandom, $urandom, 1'b0, 1'b0);
    do_mul(32'd9, 32'd11, 1'b0, 1'b0);
    @(negedge clk);
    op_a = 32'd7; op_b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_stall", {31'd0, stall}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_stall", {31'd0, stall}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_product", product, 32'd0);
    check("abort_pass_b", alu_b, pipe_b);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    check("abort_no_done", pulses, 0);
    check("abort_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
